// File: rtl/aud_seq_ctrl.sv
`default_nettype none
// ============================================================================
// aud_seq_ctrl : NUM_CH-channel record/play sequencer for the WM8731 audio path
// Revision     : 1.0
// ============================================================================
module aud_seq_ctrl #(
    parameter int                NUM_CH    = 2,
    parameter int                CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int                ADDR_W    = 20,
    parameter logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}},
    parameter logic [3:0]        SPEED_DEF = 4'd7,
    parameter logic [3:0]        SPEED_MAX = 4'd14
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init_fin,
    input  logic              i_mode,
    input  logic              i_loop,
    input  logic              i_key_start,
    input  logic              i_key_stop,
    input  logic              i_key_up,
    input  logic              i_key_down,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_dsp_fin,
    input  logic              i_io_fin,
    output logic              o_dsp_start,
    output logic              o_dsp_clear,
    output logic              o_io_start,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_mode,
    output logic [3:0]        o_speed,
    output logic [ADDR_W-1:0] o_rec_end,
    output logic              o_busy,
    output logic              o_paused
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_READY = 3'd1,
        S_DSP   = 3'd2,
        S_WAIT  = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic            MODE_PLAY = 1'b0;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              mode_q, mode_d;
    logic [3:0]        speed_q, speed_d;
    logic [3:0]        speed_next_q, speed_next_d;
    logic [ADDR_W-1:0] rec_end_q, rec_end_d;
    logic              dsp_start_q, dsp_start_d;
    logic              dsp_clear_q, dsp_clear_d;
    logic              io_start_q, io_start_d;
    logic              busy_q, busy_d;
    logic              paused_q, paused_d;
    logic              pause_req_q, pause_req_d;
    logic              stop_req_q, stop_req_d;

    logic              w_running;
    logic              w_limit;
    logic              w_pause;
    logic              w_stop;
    logic              w_loop_clr;

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        mode_d       = mode_q;
        speed_d      = speed_q;
        speed_next_d = speed_next_q;
        rec_end_d    = rec_end_q;
        dsp_start_d  = 1'b0;
        io_start_d   = 1'b0;
        pause_req_d  = 1'b0;
        stop_req_d   = 1'b0;
        w_loop_clr   = 1'b0;

        w_running = (state_q == S_DSP) || (state_q == S_WAIT);
        w_limit   = (mode_q == MODE_PLAY) ? (i_addr >= rec_end_q) : (i_addr == ADDR_MAX);
        // A key landing on the frame-end cycle itself still counts for that frame.
        w_pause   = pause_req_q || (w_running && i_key_start);
        w_stop    = stop_req_q  || (w_running && i_key_stop);

        if (state_q != S_INIT) begin
            if (i_key_up && !i_key_down && (speed_next_q < SPEED_MAX)) begin
                speed_next_d = speed_next_q + 4'd1;
            end else if (i_key_down && !i_key_up && (speed_next_q != 4'd0)) begin
                speed_next_d = speed_next_q - 4'd1;
            end
        end

        case (state_q)
            S_INIT: begin
                if (i_init_fin) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                mode_d  = i_mode;
                speed_d = speed_next_q;
                // Playback with nothing recorded has nothing to play.
                if (i_key_start && !((mode_q == MODE_PLAY) && (rec_end_q == '0))) begin
                    state_d     = S_DSP;
                    ch_d        = '0;
                    dsp_start_d = 1'b1;
                end
            end
            S_DSP: begin
                pause_req_d = w_pause;
                stop_req_d  = w_stop;
                if (i_dsp_fin && !dsp_start_q) begin
                    state_d    = S_WAIT;
                    io_start_d = 1'b1;
                end
            end
            S_WAIT: begin
                pause_req_d = w_pause;
                stop_req_d  = w_stop;
                if (i_io_fin) begin
                    if (ch_q < LAST_CH) begin
                        ch_d        = ch_q + CH_W'(1);
                        dsp_start_d = 1'b1;
                        state_d     = S_DSP;
                    end else if (w_stop || w_limit) begin
                        if (!w_stop && (mode_q == MODE_PLAY) && i_loop) begin
                            w_loop_clr  = 1'b1;
                            ch_d        = '0;
                            dsp_start_d = 1'b1;
                            state_d     = S_DSP;
                        end else begin
                            if (mode_q != MODE_PLAY) begin
                                rec_end_d = i_addr;
                            end
                            pause_req_d = 1'b0;
                            stop_req_d  = 1'b0;
                            state_d     = S_READY;
                        end
                    end else if (w_pause) begin
                        pause_req_d = 1'b0;
                        state_d     = S_PAUSE;
                    end else begin
                        ch_d        = '0;
                        speed_d     = speed_next_q;
                        dsp_start_d = 1'b1;
                        state_d     = S_DSP;
                    end
                end
            end
            S_PAUSE: begin
                if (i_key_stop) begin
                    if (mode_q != MODE_PLAY) begin
                        rec_end_d = i_addr;
                    end
                    state_d = S_READY;
                end else if (i_key_start) begin
                    ch_d        = '0;
                    speed_d     = speed_next_q;
                    dsp_start_d = 1'b1;
                    state_d     = S_DSP;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        dsp_clear_d = (state_d == S_READY) || w_loop_clr;
        busy_d      = (state_d == S_DSP) || (state_d == S_WAIT);
        paused_d    = (state_d == S_PAUSE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_INIT;
            ch_q         <= '0;
            mode_q       <= 1'b0;
            speed_q      <= SPEED_DEF;
            speed_next_q <= SPEED_DEF;
            rec_end_q    <= '0;
            dsp_start_q  <= 1'b0;
            dsp_clear_q  <= 1'b0;
            io_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            paused_q     <= 1'b0;
            pause_req_q  <= 1'b0;
            stop_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            mode_q       <= mode_d;
            speed_q      <= speed_d;
            speed_next_q <= speed_next_d;
            rec_end_q    <= rec_end_d;
            dsp_start_q  <= dsp_start_d;
            dsp_clear_q  <= dsp_clear_d;
            io_start_q   <= io_start_d;
            busy_q       <= busy_d;
            paused_q     <= paused_d;
            pause_req_q  <= pause_req_d;
            stop_req_q   <= stop_req_d;
        end
    end

    assign o_dsp_start = dsp_start_q;
    assign o_dsp_clear = dsp_clear_q;
    assign o_io_start  = io_start_q;
    assign o_ch        = ch_q;
    assign o_mode      = mode_q;
    assign o_speed     = speed_q;
    assign o_rec_end   = rec_end_q;
    assign o_busy      = busy_q;
    assign o_paused    = paused_q;

endmodule

`default_nettype wire

// File: tb/tb_aud_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_aud_seq_ctrl : scoreboard bench for the record/play sequencing controller
// Revision        : 1.0
// ============================================================================
module tb_aud_seq_ctrl;

    localparam int                NUM_CH   = 2;
    localparam int                CH_W     = 1;
    localparam int                ADDR_W   = 20;
    localparam logic [ADDR_W-1:0] ADDR_MAX = 20'hFFFFF;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_init_fin = 1'b0;
    logic              i_mode = 1'b0;
    logic              i_loop = 1'b0;
    logic              i_key_start = 1'b0;
    logic              i_key_stop = 1'b0;
    logic              i_key_up = 1'b0;
    logic              i_key_down = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_dsp_fin = 1'b0;
    logic              i_io_fin = 1'b0;
    logic              o_dsp_start;
    logic              o_dsp_clear;
    logic              o_io_start;
    logic [CH_W-1:0]   o_ch;
    logic              o_mode;
    logic [3:0]        o_speed;
    logic [ADDR_W-1:0] o_rec_end;
    logic              o_busy;
    logic              o_paused;

    aud_seq_ctrl #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_init_fin  (i_init_fin),
        .i_mode      (i_mode),
        .i_loop      (i_loop),
        .i_key_start (i_key_start),
        .i_key_stop  (i_key_stop),
        .i_key_up    (i_key_up),
        .i_key_down  (i_key_down),
        .i_addr      (i_addr),
        .i_dsp_fin   (i_dsp_fin),
        .i_io_fin    (i_io_fin),
        .o_dsp_start (o_dsp_start),
        .o_dsp_clear (o_dsp_clear),
        .o_io_start  (o_io_start),
        .o_ch        (o_ch),
        .o_mode      (o_mode),
        .o_speed     (o_speed),
        .o_rec_end   (o_rec_end),
        .o_busy      (o_busy),
        .o_paused    (o_paused)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic            io;
        logic [CH_W-1:0] ch;
        logic [3:0]      spd;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  checks = 0;
    int  errors = 0;
    int  dbl_cnt = 0;
    int  clr_busy_cnt = 0;

    // Monitor plus DSP / player model answering each start 3 cycles later.
    initial begin : mon_resp
        logic prev_ds;
        logic prev_io;
        int   dsp_cnt;
        int   io_cnt;
        ev_t  e;
        prev_ds = 1'b0; prev_io = 1'b0; dsp_cnt = 0; io_cnt = 0;
        forever begin
            @(negedge i_clk);
            if (o_dsp_start) begin e.io = 1'b0; e.ch = o_ch; e.spd = o_speed; obs_q.push_back(e); end
            if (o_io_start)  begin e.io = 1'b1; e.ch = o_ch; e.spd = o_speed; obs_q.push_back(e); end
            if ((o_dsp_start && prev_ds) || (o_io_start && prev_io)) dbl_cnt++;
            if (o_dsp_clear && o_busy) clr_busy_cnt++;
            prev_ds = o_dsp_start;
            prev_io = o_io_start;
            i_dsp_fin = 1'b0;
            i_io_fin  = 1'b0;
            if (!i_rst_n) begin
                dsp_cnt = 0; io_cnt = 0;
            end else begin
                if (dsp_cnt > 0) begin dsp_cnt--; if (dsp_cnt == 0) i_dsp_fin = 1'b1; end
                if (io_cnt > 0)  begin io_cnt--;  if (io_cnt == 0)  i_io_fin  = 1'b1; end
                if (o_dsp_start) dsp_cnt = 3;
                if (o_io_start)  io_cnt  = 3;
            end
        end
    end

    function automatic ev_t mk(input logic io, input logic [CH_W-1:0] ch, input logic [3:0] spd);
        ev_t e;
        e.io = io; e.ch = ch; e.spd = spd;
        return e;
    endfunction

    task automatic push_frame(input logic [3:0] spd);
        for (int c = 0; c < NUM_CH; c++) begin
            exp_q.push_back(mk(1'b0, CH_W'(c), spd));
            exp_q.push_back(mk(1'b1, CH_W'(c), spd));
        end
    endtask

    task automatic press(input logic s, input logic p, input logic u, input logic d, input int n);
        @(negedge i_clk);
        i_key_start = s; i_key_stop = p; i_key_up = u; i_key_down = d;
        repeat (n) @(negedge i_clk);
        i_key_start = 1'b0; i_key_stop = 1'b0; i_key_up = 1'b0; i_key_down = 1'b0;
    endtask

    task automatic wait_obs(input int n, output bit to);
        int k;
        k = 0;
        while ((obs_q.size() < n) && (k < 500)) begin @(negedge i_clk); k++; end
        to = (obs_q.size() < n);
    endtask

    // kind 0: wait for not busy; kind 1: wait for paused
    task automatic wait_st(input int kind, output bit to);
        int k;
        k = 0;
        while ((kind == 0 ? o_busy : !o_paused) && (k < 500)) begin @(negedge i_clk); k++; end
        to = (kind == 0) ? o_busy : !o_paused;
    endtask

    task automatic test_reset();
        checks++;
        if ({o_dsp_start, o_io_start, o_dsp_clear, o_busy, o_paused} !== 5'b0) begin
            errors++; $display("FAIL rst_flags: got %05b expected 00000",
                {o_dsp_start, o_io_start, o_dsp_clear, o_busy, o_paused});
        end
        checks++;
        if (o_ch !== '0 || o_mode !== 1'b0 || o_speed !== 4'd7 || o_rec_end !== '0) begin
            errors++; $display("FAIL rst_regs: got ch=%0d mode=%0d spd=%0d end=%h expected 0 0 7 0",
                o_ch, o_mode, o_speed, o_rec_end);
        end
        @(negedge i_clk); i_rst_n = 1'b1;
        press(1'b1, 1'b0, 1'b1, 1'b0, 1);
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_dsp_clear !== 1'b0 || obs_q.size() != 0) begin
            errors++; $display("FAIL init_keys: got busy=%0d clr=%0d ev=%0d expected 0 0 0",
                o_busy, o_dsp_clear, obs_q.size());
        end
        i_init_fin = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_dsp_clear !== 1'b1 || o_speed !== 4'd7) begin
            errors++; $display("FAIL ready_entry: got clr=%0d spd=%0d expected 1 7", o_dsp_clear, o_speed);
        end
    endtask

    task automatic test_record();
        bit  to;
        ev_t e, o;
        i_mode = 1'b1; i_addr = 20'h00123;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_mode !== 1'b1) begin errors++; $display("FAIL rec_mode: got %0d expected 1", o_mode); end
        push_frame(4'd7); push_frame(4'd7);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        checks++;
        if (o_dsp_start !== 1'b1 || o_ch !== '0) begin
            errors++; $display("FAIL rec_start: got start=%0d ch=%0d expected 1 0", o_dsp_start, o_ch);
        end
        wait_obs(5, to);
        press(1'b0, 1'b1, 1'b0, 1'b0, 1);
        wait_st(0, to);
        checks++;
        if (to) begin errors++; $display("FAIL rec_idle timeout: got busy=%0d expected 0", o_busy); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rec_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL rec_event: got io=%0d ch=%0d spd=%0d expected io=%0d ch=%0d spd=%0d",
                    o.io, o.ch, o.spd, e.io, e.ch, e.spd);
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (o_rec_end !== 20'h00123 || o_dsp_clear !== 1'b1) begin
            errors++; $display("FAIL rec_end: got end=%h clr=%0d expected 00123 1", o_rec_end, o_dsp_clear);
        end
    endtask

    task automatic test_record_limit();
        bit  to;
        ev_t e, o;
        i_addr = '0;
        push_frame(4'd7);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        wait_obs(1, to);
        i_addr = ADDR_MAX;
        wait_st(0, to);
        checks++;
        if (to) begin errors++; $display("FAIL lim_idle timeout: got busy=%0d expected 0", o_busy); end
        repeat (10) @(negedge i_clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL lim_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL lim_event: got io=%0d ch=%0d spd=%0d expected io=%0d ch=%0d spd=%0d",
                    o.io, o.ch, o.spd, e.io, e.ch, e.spd);
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (o_rec_end !== 20'hFFFFF) begin errors++; $display("FAIL lim_end: got %h expected fffff", o_rec_end); end
    endtask

    task automatic test_loop();
        bit  to;
        int  clr0;
        ev_t e, o;
        i_addr = 20'h00010;
        push_frame(4'd7);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        press(1'b0, 1'b1, 1'b0, 1'b0, 1);
        wait_st(0, to);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL loop_rec_event: got io=%0d ch=%0d spd=%0d expected io=%0d ch=%0d spd=%0d",
                    o.io, o.ch, o.spd, e.io, e.ch, e.spd);
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (o_rec_end !== 20'h00010) begin errors++; $display("FAIL loop_rec_end: got %h expected 00010", o_rec_end); end
        i_mode = 1'b0; i_loop = 1'b1;
        repeat (2) @(negedge i_clk);
        clr0 = clr_busy_cnt;
        push_frame(4'd7); push_frame(4'd7);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        wait_obs(5, to);
        checks++;
        if (to || clr_busy_cnt - clr0 != 1 || o_busy !== 1'b1 || o_ch !== '0) begin
            errors++; $display("FAIL loop_restart: got to=%0d clr=%0d busy=%0d ch=%0d expected 0 1 1 0",
                to, clr_busy_cnt - clr0, o_busy, o_ch);
        end
        i_loop = 1'b0;
        wait_st(0, to);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL loop_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL loop_event: got io=%0d ch=%0d spd=%0d expected io=%0d ch=%0d spd=%0d",
                    o.io, o.ch, o.spd, e.io, e.ch, e.spd);
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (clr_busy_cnt - clr0 != 1 || o_rec_end !== 20'h00010) begin
            errors++; $display("FAIL loop_end: got clr=%0d end=%h expected 1 00010", clr_busy_cnt - clr0, o_rec_end);
        end
    endtask

    task automatic test_pause();
        bit  to;
        ev_t e, o;
        i_addr = '0;
        push_frame(4'd7); push_frame(4'd7);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        wait_obs(2, to);
        checks++;
        if (o_ch !== '0) begin errors++; $display("FAIL pause_ch: got %0d expected 0", o_ch); end
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        wait_st(1, to);
        checks++;
        if (to || o_busy !== 1'b0 || obs_q.size() != 4) begin
            errors++; $display("FAIL pause_enter: got to=%0d busy=%0d ev=%0d expected 0 0 4", to, o_busy, obs_q.size());
        end
        repeat (8) @(negedge i_clk);
        checks++;
        if (obs_q.size() != 4 || o_paused !== 1'b1) begin
            errors++; $display("FAIL pause_hold: got ev=%0d paused=%0d expected 4 1", obs_q.size(), o_paused);
        end
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        checks++;
        if (o_dsp_start !== 1'b1 || o_paused !== 1'b0) begin
            errors++; $display("FAIL pause_resume: got start=%0d paused=%0d expected 1 0", o_dsp_start, o_paused);
        end
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        wait_st(1, to);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL pause_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL pause_event: got io=%0d ch=%0d spd=%0d expected io=%0d ch=%0d spd=%0d",
                    o.io, o.ch, o.spd, e.io, e.ch, e.spd);
            end
        end
        exp_q.delete(); obs_q.delete();
        press(1'b1, 1'b1, 1'b0, 1'b0, 1);
        repeat (5) @(negedge i_clk);
        checks++;
        if (o_paused !== 1'b0 || o_dsp_clear !== 1'b1 || o_busy !== 1'b0 || obs_q.size() != 0
            || o_rec_end !== 20'h00010) begin
            errors++; $display("FAIL pause_stop: got paused=%0d clr=%0d busy=%0d ev=%0d end=%h expected 0 1 0 0 00010",
                o_paused, o_dsp_clear, o_busy, obs_q.size(), o_rec_end);
        end
    endtask

    task automatic test_speed();
        bit  to;
        ev_t e, o;
        push_frame(4'd7); push_frame(4'd14);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        wait_obs(1, to);
        i_mode = 1'b1;
        press(1'b0, 1'b0, 1'b1, 1'b0, 8);
        checks++;
        if (o_speed !== 4'd7 || o_mode !== 1'b0) begin
            errors++; $display("FAIL speed_midframe: got spd=%0d mode=%0d expected 7 0", o_speed, o_mode);
        end
        wait_obs(5, to);
        i_mode = 1'b0;
        press(1'b0, 1'b1, 1'b0, 1'b0, 1);
        wait_st(0, to);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL speed_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL speed_event: got io=%0d ch=%0d spd=%0d expected io=%0d ch=%0d spd=%0d",
                    o.io, o.ch, o.spd, e.io, e.ch, e.spd);
            end
        end
        exp_q.delete(); obs_q.delete();
        press(1'b0, 1'b0, 1'b1, 1'b1, 1);
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_speed !== 4'd14) begin errors++; $display("FAIL speed_both: got %0d expected 14", o_speed); end
        press(1'b0, 1'b0, 1'b0, 1'b1, 15);
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_speed !== 4'd0) begin errors++; $display("FAIL speed_floor: got %0d expected 0", o_speed); end
        press(1'b0, 1'b0, 1'b1, 1'b0, 7);
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_speed !== 4'd7) begin errors++; $display("FAIL speed_restore: got %0d expected 7", o_speed); end
    endtask

    task automatic test_reset_empty();
        bit to;
        i_mode = 1'b1;
        press(1'b0, 1'b0, 1'b1, 1'b0, 1);
        repeat (2) @(negedge i_clk);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        wait_obs(2, to);
        #2;
        i_rst_n = 1'b0; i_init_fin = 1'b0;
        #1;
        checks++;
        if ({o_dsp_start, o_io_start, o_dsp_clear, o_busy, o_paused} !== 5'b0) begin
            errors++; $display("FAIL async_rst_flags: got %05b expected 00000",
                {o_dsp_start, o_io_start, o_dsp_clear, o_busy, o_paused});
        end
        checks++;
        if (o_ch !== '0 || o_mode !== 1'b0 || o_speed !== 4'd7 || o_rec_end !== '0) begin
            errors++; $display("FAIL async_rst_regs: got ch=%0d mode=%0d spd=%0d end=%h expected 0 0 7 0",
                o_ch, o_mode, o_speed, o_rec_end);
        end
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        obs_q.delete(); exp_q.delete();
        i_mode = 1'b0; i_init_fin = 1'b1;
        repeat (3) @(negedge i_clk);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1);
        checks++;
        if (o_dsp_start !== 1'b0) begin errors++; $display("FAIL empty_start: got %0d expected 0", o_dsp_start); end
        repeat (10) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_dsp_clear !== 1'b1 || obs_q.size() != 0) begin
            errors++; $display("FAIL empty_ready: got busy=%0d clr=%0d ev=%0d expected 0 1 0",
                o_busy, o_dsp_clear, obs_q.size());
        end
        checks++;
        if (dbl_cnt != 0) begin errors++; $display("FAIL pulse_width: got %0d long pulses expected 0", dbl_cnt); end
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        test_reset();
        test_record();
        test_record_limit();
        test_loop();
        test_pause();
        test_speed();
        test_reset_empty();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/aud_seq_ctrl.md
Name: aud_seq_ctrl

Overview:
Parametrised record/play sequencing controller for the WM8731 audio path. It sits between the board keys/switches and the AudDSP / AudPlayer / AudRecorder handshakes. The controller generalises the single stereo L/R sequence to NUM_CH channels per frame and adds the following:
- latched pause/stop requests;
- a saturating speed register;
- recorded-length tracking;
- loop playback.

Parameters:
NUM_CH, 2, channels per frame (>=1); channel index runs 0..NUM_CH-1
CH_W, $clog2(NUM_CH) (min 1), width of o_ch
ADDR_W, 20, SRAM sample address width
ADDR_MAX, 2**ADDR_W-1, last writable address; reaching it ends a recording
SPEED_DEF, 7, reset/default speed code (7 = 1x)
SPEED_MAX, 14, top speed code (0 = 1/8 ... 14 = 8x)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  async active-low reset
i_init_fin  in  1  codec I2C init complete (level or pulse)
i_mode  in  1  0 = play, 1 = record (switch)
i_loop  in  1  1 = loop playback at recorded end
i_key_start  in  1  start/pause, one-cycle debounced pulse
i_key_stop  in  1  stop, one-cycle pulse
i_key_up  in  1  speed up, one-cycle pulse
i_key_down  in  1  speed down, one-cycle pulse
i_addr  in  ADDR_W  current sample address from DSP
i_dsp_fin  in  1  DSP finished current channel
i_io_fin  in  1  player/recorder finished current channel
o_dsp_start  out  1  one-cycle DSP start pulse
o_dsp_clear  out  1  DSP address/state clear
o_io_start  out  1  one-cycle player/recorder start pulse
o_ch  out  CH_W  channel being processed
o_mode  out  1  latched mode
o_speed  out  4  speed code applied to the current frame
o_rec_end  out  ADDR_W  last recorded address
o_busy  out  1  state is S_DSP or S_WAIT
o_paused  out  1  state is S_PAUSE

Behaviour:
- Reset values: state S_INIT; o_ch = 0; o_mode = 0; o_speed = SPEED_DEF; speed_next = SPEED_DEF; o_rec_end = 0; all pulses 0; pause_req = 0; stop_req = 0. Reset mid-operation aborts immediately, with no final pulses.
- All outputs are registered. Handshake pulses are high for exactly one cycle.
- S_INIT: waits for i_init_fin, then goes to S_READY. Keys are ignored in S_INIT.
- S_READY:
  - o_dsp_clear = 1 while in this state.
  - o_mode <= i_mode every cycle.
  - o_speed <= speed_next every cycle.
  - On i_key_start: go to S_DSP with o_ch = 0 and o_dsp_start = 1 on the next cycle. Exception: if o_mode = play and o_rec_end = 0, i_key_start is ignored (nothing recorded).
- S_DSP: on i_dsp_fin, go to S_WAIT and pulse o_io_start on the next cycle. i_dsp_fin is ignored in the cycle o_dsp_start is high.
- S_WAIT: on i_io_fin:
  - If o_ch < NUM_CH-1: o_ch++, pulse o_dsp_start, go to S_DSP.
  - Otherwise (frame end), evaluate in priority order:
    1. stop_req or limit: in record mode, o_rec_end <= i_addr; clear both requests; go to S_READY. Exception: play mode with i_loop = 1 and limit (and no stop_req) pulses o_dsp_clear for one cycle, sets o_ch = 0, pulses o_dsp_start, and stays running.
    2. pause_req: clear it; go to S_PAUSE.
    3. Else: o_ch = 0, o_speed <= speed_next, pulse o_dsp_start, go to S_DSP.
- limit: record mode means i_addr == ADDR_MAX; play mode means i_addr >= o_rec_end.
- Requests while running (S_DSP/S_WAIT): i_key_start sets pause_req and i_key_stop sets stop_req. Both are sticky until the frame end. A second i_key_start does not cancel pause_req.
- S_PAUSE:
  - i_key_stop: in record mode, o_rec_end <= i_addr; go to S_READY.
  - Else i_key_start: o_ch = 0, o_speed <= speed_next, pulse o_dsp_start, go to S_DSP.
  - If both arrive in the same cycle, stop wins.
- Speed: speed_next increments on i_key_up (saturates at SPEED_MAX) and decrements on i_key_down (saturates at 0). Both in the same cycle means no change. Updates in any state except S_INIT. o_speed changes only at frame boundaries or in S_READY, never mid-frame.
- o_mode never changes outside S_READY.

Test Plan:
- Record start with NUM_CH = 2: init_fin, key_start, each dsp_fin/io_fin returned 3 cycles after its start -> pulse order dsp, io, dsp, io per frame; o_ch follows 0, 1, 0, 1 -> key_stop mid-frame; frame completes; S_READY; o_rec_end = i_addr (e.g. 0x00123).
- Record limit: i_addr = ADDR_MAX at frame end -> S_READY, o_rec_end = 0xFFFFF, no further o_dsp_start.
- Play with i_loop = 1, o_rec_end = 0x10, i_addr = 0x10 at frame end -> one-cycle o_dsp_clear plus o_dsp_start, o_ch = 0, still busy. With i_loop = 0 -> S_READY.
- Pause: key_start while in S_WAIT with o_ch = 0 -> frame finishes channel 1, then o_paused = 1. Next key_start resumes with o_dsp_start on the following cycle. key_start + key_stop in the same cycle while paused -> S_READY.
- Speed: 8 key_up pulses from 7 -> speed_next = 14 (saturated); o_speed stays 7 until the next frame boundary, then 14. key_up and key_down in the same cycle -> unchanged. 15 key_down pulses -> 0.
- Reset and empty play: assert i_rst_n low in S_WAIT -> all outputs at reset values immediately. After re-init in play mode, key_start with o_rec_end = 0 -> stays in S_READY.
